// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcodes, FSM states and default width for the sequential ALU
package alu_seq_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_muldiv.sv
// rtl/alu_seq_muldiv.sv - shared iterative shift-add multiply / restoring divide on operand magnitudes
// Outputs are the sign-corrected result after the step taken this cycle, valid when o_last is high.
module alu_seq_muldiv import alu_seq_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_last,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

    logic             r_div;
    logic             r_sa;
    logic             r_sb;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_md;
    logic [SHW-1:0]   r_cnt;

    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [WIDTH-1:0]   w_hi_n;
    logic [WIDTH-1:0]   w_lo_n;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_s;

    // hi holds the partial product / partial remainder, lo the multiplier / quotient bits
    assign w_addend = r_lo[0] ? r_md : '0;
    assign w_sum    = {1'b0, r_hi} + {1'b0, w_addend};
    assign w_shift  = {r_hi, r_lo[WIDTH-1]};
    assign w_diff   = w_shift - {1'b0, r_md};
    assign w_ge     = ~w_diff[WIDTH];

    assign w_hi_n = r_div ? (w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0]) : w_sum[WIDTH:1];
    assign w_lo_n = r_div ? {r_lo[WIDTH-2:0], w_ge} : {w_sum[0], r_lo[WIDTH-1:1]};

    assign w_prod   = {w_hi_n, w_lo_n};
    assign w_prod_s = (r_sa ^ r_sb) ? -w_prod : w_prod;

    // remainder follows the dividend sign, quotient the sign of the product
    assign o_hi   = r_div ? (r_sa ? -w_hi_n : w_hi_n) : w_prod_s[2*WIDTH-1:WIDTH];
    assign o_lo   = r_div ? ((r_sa ^ r_sb) ? -w_lo_n : w_lo_n) : w_prod_s[WIDTH-1:0];
    assign o_last = (r_cnt == '0);

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_div <= 1'b0;
            r_sa  <= 1'b0;
            r_sb  <= 1'b0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_md  <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_div <= i_div;
            r_sa  <= i_a[WIDTH-1];
            r_sb  <= i_b[WIDTH-1];
            r_hi  <= '0;
            r_lo  <= f_mag(i_a);
            r_md  <= f_mag(i_b);
            r_cnt <= SHW'(WIDTH - 1);
        end else if (i_step) begin
            r_hi  <= w_hi_n;
            r_lo  <= w_lo_n;
            r_cnt <= r_cnt - SHW'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with start/busy/done and iterative signed mul/div
// Optional flag outputs flag_z/flag_n/flag_c are built only when ALU_SEQ_FLAGS_EN is defined.
module alu_seq import alu_seq_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z_high,
    output logic [WIDTH-1:0] z_low,
    output logic             div_by_zero
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c
`endif
);

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_z_high;
    logic [WIDTH-1:0] r_z_low;
    logic             r_dbz;

    logic             w_b_zero;
    logic             w_is_div;
    logic             w_long;
    logic             w_load;
    logic             w_step;
    logic             w_last;
    logic [WIDTH-1:0] w_md_hi;
    logic [WIDTH-1:0] w_md_lo;
    logic             w_big;
    logic [SHW-1:0]   w_cnt;
    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_lo;

`ifdef ALU_SEQ_FLAGS_EN
    logic             r_flag_z;
    logic             r_flag_n;
    logic             r_flag_c;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic             w_carry;

    assign w_add   = {1'b0, a_in} + {1'b0, b_in};
    assign w_sub   = {1'b0, a_in} - {1'b0, b_in};
    assign w_carry = (op == OP_ADD || op == OP_ADDI) ? w_add[WIDTH]
                   : (op == OP_SUB) ? ~w_sub[WIDTH] : 1'b0;
    assign flag_z  = r_flag_z;
    assign flag_n  = r_flag_n;
    assign flag_c  = r_flag_c;
`else
    logic [WIDTH-1:0] w_add;
    logic [WIDTH-1:0] w_sub;

    assign w_add = a_in + b_in;
    assign w_sub = a_in - b_in;
`endif

    assign w_b_zero = (b_in == '0);
    assign w_is_div = (op == OP_DIV);
    assign w_long   = (op == OP_MUL) || (w_is_div && !w_b_zero);
    assign w_load   = (r_state == S_IDLE) && start && w_long;
    assign w_step   = (r_state == S_ITER);
    assign w_big    = |b_in[WIDTH-1:SHW];
    assign w_cnt    = b_in[SHW-1:0];

    alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clock  (clock),
        .clear  (clear),
        .i_load (w_load),
        .i_step (w_step),
        .i_div  (w_is_div),
        .i_a    (a_in),
        .i_b    (b_in),
        .o_last (w_last),
        .o_hi   (w_md_hi),
        .o_lo   (w_md_lo)
    );

    // single-cycle results; only sampled on the accepting edge, so they match the latched operands
    always_comb begin
        w_hi = '0;
        w_lo = '0;
        case (op)
            OP_ADD, OP_ADDI: w_lo = w_add[WIDTH-1:0];
            OP_SUB:          w_lo = w_sub[WIDTH-1:0];
            OP_AND, OP_ANDI: w_lo = a_in & b_in;
            OP_OR, OP_ORI:   w_lo = a_in | b_in;
            OP_SHR:          w_lo = w_big ? '0 : (a_in >> w_cnt);
            OP_SHRA:         w_lo = w_big ? {WIDTH{a_in[WIDTH-1]}} : ($signed(a_in) >>> w_cnt);
            OP_SHL:          w_lo = w_big ? '0 : (a_in << w_cnt);
            OP_ROR:          w_lo = (a_in >> w_cnt) | (a_in << (WIDTH - int'(w_cnt)));
            OP_ROL:          w_lo = (a_in << w_cnt) | (a_in >> (WIDTH - int'(w_cnt)));
            OP_NEG:          w_lo = -b_in;
            OP_NOT:          w_lo = ~b_in;
            OP_DIV: begin
                w_lo = '1;
                w_hi = a_in;
            end
            default: begin
                w_hi = '0;
                w_lo = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_z_high <= '0;
            r_z_low  <= '0;
            r_dbz    <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
            r_flag_z <= 1'b0;
            r_flag_n <= 1'b0;
            r_flag_c <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_dbz <= w_is_div && w_b_zero;
                        if (w_long) begin
                            r_state <= S_ITER;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state  <= S_FIN;
                            r_done   <= 1'b1;
                            r_z_high <= w_hi;
                            r_z_low  <= w_lo;
`ifdef ALU_SEQ_FLAGS_EN
                            r_flag_z <= (w_lo == '0);
                            r_flag_n <= w_lo[WIDTH-1];
                            r_flag_c <= w_carry;
`endif
                        end
                    end
                end
                S_ITER: begin
                    if (w_last) begin
                        r_state  <= S_FIN;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_z_high <= w_md_hi;
                        r_z_low  <= w_md_lo;
`ifdef ALU_SEQ_FLAGS_EN
                        r_flag_z <= (w_md_lo == '0);
                        r_flag_n <= w_md_lo[WIDTH-1];
                        r_flag_c <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign z_high      = r_z_high;
    assign z_low       = r_z_low;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized and directed bench for alu_seq at WIDTH=32 and WIDTH=8
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic        clock = 1'b0;
    logic        clear;
    logic [4:0]  op;
    logic        st32, st8;
    logic [31:0] a32, b32;
    logic [7:0]  a8, b8;
    logic        busy32, done32, dbz32, busy8, done8, dbz8;
    logic [31:0] zh32, zl32;
    logic [7:0]  zh8, zl8;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    alu_seq #(.WIDTH(32)) dut32 (
        .clock(clock), .clear(clear), .start(st32), .op(op), .a_in(a32), .b_in(b32),
        .busy(busy32), .done(done32), .z_high(zh32), .z_low(zl32), .div_by_zero(dbz32)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clock(clock), .clear(clear), .start(st8), .op(op), .a_in(a8), .b_in(b8),
        .busy(busy8), .done(done8), .z_high(zh8), .z_low(zl8), .div_by_zero(dbz8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference: plain signed/unsigned arithmetic on 64-bit integers
    function automatic void model(input int w, input logic [4:0] o,
                                  input longint unsigned a, input longint unsigned b,
                                  output longint unsigned hi, output longint unsigned lo,
                                  output bit dbz, output int lat);
        longint unsigned mask, c;
        longint sa, sb, p, t;
        mask = (64'd1 << w) - 64'd1;
        sa = (a >> (w - 1)) != 0 ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb = (b >> (w - 1)) != 0 ? longint'(b) - (longint'(1) << w) : longint'(b);
        hi = 0; lo = 0; dbz = 0; lat = 1;
        case (o)
            OP_ADD, OP_ADDI: lo = (a + b) & mask;
            OP_SUB:          lo = (a - b) & mask;
            OP_AND, OP_ANDI: lo = a & b;
            OP_OR, OP_ORI:   lo = a | b;
            OP_SHR:          lo = (b >= w) ? 0 : (a >> b);
            OP_SHL:          lo = (b >= w) ? 0 : ((a << b) & mask);
            OP_SHRA: begin
                t = sa >>> ((b >= w) ? longint'(w - 1) : longint'(b));
                lo = t & mask;
            end
            OP_ROR: begin
                c = b % w;
                lo = ((a >> c) | (a << (w - c))) & mask;
            end
            OP_ROL: begin
                c = b % w;
                lo = ((a << c) | (a >> (w - c))) & mask;
            end
            OP_MUL: begin
                p = sa * sb;
                t = p >>> w;
                hi = t & mask;
                lo = p & mask;
                lat = w + 1;
            end
            OP_DIV: begin
                if (b == 0) begin
                    lo = mask; hi = a; dbz = 1;
                end else begin
                    p = sa / sb;
                    t = sa % sb;
                    lo = p & mask;
                    hi = t & mask;
                    lat = w + 1;
                end
            end
            OP_NEG: lo = (0 - b) & mask;
            OP_NOT: lo = (~b) & mask;
            default: begin hi = 0; lo = 0; end
        endcase
    endfunction

    function automatic logic g_done(input int w); return (w == 32) ? done32 : done8; endfunction
    function automatic logic g_busy(input int w); return (w == 32) ? busy32 : busy8; endfunction
    function automatic logic g_dbz(input int w);  return (w == 32) ? dbz32 : dbz8;   endfunction
    function automatic logic [63:0] g_hi(input int w); return (w == 32) ? {32'b0, zh32} : {56'b0, zh8}; endfunction
    function automatic logic [63:0] g_lo(input int w); return (w == 32) ? {32'b0, zl32} : {56'b0, zl8}; endfunction

    // issue one op, optionally pulse a stray add start at cycle inj, and check everything
    task automatic run(input int w, input logic [4:0] o, input logic [31:0] a, input logic [31:0] b, input int inj);
        longint unsigned ehi, elo, ma, mb;
        bit edbz;
        int elat, cyc, nb;
        string tag;
        ma = (w == 32) ? {32'b0, a} : {56'b0, a[7:0]};
        mb = (w == 32) ? {32'b0, b} : {56'b0, b[7:0]};
        model(w, o, ma, mb, ehi, elo, edbz, elat);
        tag = $sformatf("w%0d op%05b a=%0h b=%0h", w, o, ma, mb);
        @(negedge clock);
        op = o;
        a32 = ma[31:0]; b32 = mb[31:0]; a8 = ma[7:0]; b8 = mb[7:0];
        if (w == 32) st32 = 1'b1; else st8 = 1'b1;
        @(negedge clock);
        st32 = 1'b0; st8 = 1'b0;
        op = 5'($urandom); a32 = $urandom; b32 = $urandom; a8 = 8'($urandom); b8 = 8'($urandom);
        cyc = 1; nb = 0;
        while (!g_done(w) && cyc <= 80) begin
            if (g_busy(w)) nb++;
            if (cyc == inj) begin
                op = OP_ADD;
                if (w == 32) st32 = 1'b1; else st8 = 1'b1;
            end else begin
                st32 = 1'b0; st8 = 1'b0;
            end
            @(negedge clock);
            cyc++;
        end
        st32 = 1'b0; st8 = 1'b0;
        check({tag, " latency"}, 64'(cyc), 64'(elat));
        check({tag, " busy_cycles"}, 64'(nb), 64'(elat - 1));
        check({tag, " busy_at_done"}, 64'(g_busy(w)), 64'd0);
        check({tag, " z_high"}, g_hi(w), ehi);
        check({tag, " z_low"}, g_lo(w), elo);
        check({tag, " div_by_zero"}, 64'(g_dbz(w)), 64'(edbz));
        @(negedge clock);
        check({tag, " done_pulse"}, 64'(g_done(w)), 64'd0);
        check({tag, " z_low_held"}, g_lo(w), elo);
    endtask

    logic [4:0] op_tab [0:17] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR,
                                  OP_ROL, OP_ADDI, OP_ANDI, OP_ORI, OP_MUL, OP_DIV, OP_NEG, OP_NOT,
                                  5'b00000, 5'b11111};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] ra, rb;
        int w, sel;
        clear = 1'b1; op = '0; st32 = 1'b0; st8 = 1'b0;
        a32 = '0; b32 = '0; a8 = '0; b8 = '0;
        repeat (2) @(negedge clock);
        check("reset busy", 64'(busy32), 64'd0);
        check("reset done", 64'(done32), 64'd0);
        check("reset z_high", 64'(zh32), 64'd0);
        check("reset z_low", 64'(zl32), 64'd0);
        check("reset div_by_zero", 64'(dbz32), 64'd0);
        clear = 1'b0;

        run(32, OP_ADD, 32'd7, 32'd5, 0);
        run(32, OP_MUL, 32'hFFFFFFFD, 32'd4, 10);
        run(32, OP_DIV, 32'hFFFFFFF9, 32'd2, 0);
        run(32, OP_DIV, 32'h0000002A, 32'd0, 0);
        run(32, OP_ADD, 32'd1, 32'd2, 0);
        run(32, OP_SHL, 32'd1, 32'd33, 0);
        run(32, OP_SHRA, 32'h80000000, 32'd40, 0);
        run(32, OP_ROL, 32'h80000001, 32'd33, 0);
        run(32, OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0);
        run(32, 5'b11111, 32'h12345678, 32'h9, 0);
        run(32, OP_MUL, 32'h00001234, 32'hFFFF0001, 0);

        // asynchronous clear in the middle of a multiply
        @(negedge clock);
        op = OP_MUL; a32 = 32'hFFFFFFFD; b32 = 32'd4; st32 = 1'b1;
        @(negedge clock);
        st32 = 1'b0;
        repeat (4) @(negedge clock);
        check("abort busy_before_clear", 64'(busy32), 64'd1);
        #2 clear = 1'b1;
        #1;
        check("abort busy", 64'(busy32), 64'd0);
        check("abort done", 64'(done32), 64'd0);
        check("abort z_high", 64'(zh32), 64'd0);
        check("abort z_low", 64'(zl32), 64'd0);
        #1 clear = 1'b0;
        run(32, OP_ADD, 32'd7, 32'd5, 0);

        run(8, OP_ADD, 32'd7, 32'd5, 0);
        run(8, OP_MUL, 32'hFD, 32'd4, 3);
        run(8, OP_DIV, 32'hF9, 32'd2, 0);
        run(8, OP_DIV, 32'h80, 32'hFF, 0);
        run(8, OP_SHRA, 32'h80, 32'd9, 0);

        for (int i = 0; i < 48; i++) begin
            w = (i % 2 == 0) ? 32 : 8;
            sel = $urandom_range(0, 17);
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(0, 40);
                default: rb = $urandom;
            endcase
            run(w, op_tab[sel], ra, rb, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
